// File: rtl/regfile_param.sv
// regfile_param: parametrised integer register file.
//   DEPTH words of WIDTH bits.
//   Two combinational read ports and one clocked write port.
//   The write port has a write enable per 16-bit lane.
//   Index ZERO_REG always reads 0 and ignores writes.
//   If ZERO_REG >= DEPTH, there is no zero register.
// Optional feature: define REGFILE_BYPASS_EN to forward write data to the read ports
// in the same cycle. Forwarding is per lane and only for enabled lanes.

// One 16-bit storage slice with its own enable.
module regfile_slice16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // The slice clears asynchronously on reset and loads d only when its lane is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// One WIDTH-bit register built from WIDTH/16 independently enabled 16-bit slices.
module regfile_lanereg #(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH/16-1:0]   laneen,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q
);

  localparam int LANES = WIDTH / 16;

  for (genvar k = 0; k < LANES; k++) begin : g_slice
    regfile_slice16 u_slice (
      .clk   (clk),
      .reset (reset),
      .en    (laneen[k]),
      .d     (d[16*k +: 16]),
      .q     (q[16*k +: 16])
    );
  end

endmodule

// Top level: storage array, one-hot write decode and two read multiplexers.
module regfile_param #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     ReadRegister1,
  input  logic [ADDR_W-1:0]     ReadRegister2,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2,
  input  logic [ADDR_W-1:0]     WriteRegister,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic                  RegWrite,
  input  logic [WIDTH/16-1:0]   LaneEn
);

  localparam int LANES = WIDTH / 16;

  logic [WIDTH-1:0] regq [DEPTH];
  logic [LANES-1:0] laneen_r [DEPTH];
  logic [DEPTH-1:0] wrsel;
  logic             wrvalid;

  // An address is backed by storage only if it is in range and is not the zero register.
  // An out-of-range address never aliases onto a real index.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
  endfunction

  assign wrvalid = addr_ok(WriteRegister);

  // Decode the write address to a one-hot select.
  // The select is gated by RegWrite and by address validity.
  always_comb begin
    wrsel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RegWrite && wrvalid && (int'(WriteRegister) == i)) begin
        wrsel[i] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    assign laneen_r[i] = wrsel[i] ? LaneEn : '0;

    regfile_lanereg #(.WIDTH(WIDTH)) u_reg (
      .clk    (clk),
      .reset  (reset),
      .laneen (laneen_r[i]),
      .d      (WriteData),
      .q      (regq[i])
    );
  end

  // Read port 1: select the addressed word, or 0 for the zero register and out-of-range
  // addresses. Optionally forward the enabled write lanes.
  always_comb begin
    ReadData1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_ok(ReadRegister1) && (int'(ReadRegister1) == i)) begin
        ReadData1 = regq[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (!reset && RegWrite && wrvalid && (ReadRegister1 == WriteRegister)) begin
      for (int k = 0; k < LANES; k++) begin
        if (LaneEn[k]) begin
          ReadData1[16*k +: 16] = WriteData[16*k +: 16];
        end
      end
    end
`endif
  end

  // Read port 2: same selection and forwarding rules as port 1, independent address.
  always_comb begin
    ReadData2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_ok(ReadRegister2) && (int'(ReadRegister2) == i)) begin
        ReadData2 = regq[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (!reset && RegWrite && wrvalid && (ReadRegister2 == WriteRegister)) begin
      for (int k = 0; k < LANES; k++) begin
        if (LaneEn[k]) begin
          ReadData2[16*k +: 16] = WriteData[16*k +: 16];
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param.
// Two DUT instances share all inputs:
//   dutA: DEPTH=32, ZERO_REG=31
//   dutB: DEPTH=24, ZERO_REG=31 (no zero register inside the range)
// Each instance is compared against a word-array model of the register file.
// Directed checks with literal expected values are also included.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rr1 = '0;
  logic [4:0]  rr2 = '0;
  logic [4:0]  wr = '0;
  logic [63:0] wd = '0;
  logic        we = 1'b0;
  logic [3:0]  lane = '0;
  logic [63:0] rd1a, rd2a, rd1b, rd2b;

  int checks = 0;
  int failures = 0;

  logic [63:0] memA [32];
  logic [63:0] memB [32];

  regfile_param #(.WIDTH(64), .DEPTH(32), .ADDR_W(5), .ZERO_REG(31)) dutA (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister1 (rr1),
    .ReadRegister2 (rr2),
    .ReadData1     (rd1a),
    .ReadData2     (rd2a),
    .WriteRegister (wr),
    .WriteData     (wd),
    .RegWrite      (we),
    .LaneEn        (lane)
  );

  regfile_param #(.WIDTH(64), .DEPTH(24), .ADDR_W(5), .ZERO_REG(31)) dutB (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister1 (rr1),
    .ReadRegister2 (rr2),
    .ReadData1     (rd1b),
    .ReadData2     (rd2b),
    .WriteRegister (wr),
    .WriteData     (wd),
    .RegWrite      (we),
    .LaneEn        (lane)
  );

  always #5 clk = ~clk;

  // Expected read value: the stored word, 0 for invalid addresses, and forwarded lanes when enabled.
  function automatic logic [63:0] modelRead(input int m, input logic [4:0] a);
    int depth = (m == 0) ? 32 : 24;
    logic [63:0] v;
    if (reset) return 64'h0;
    if (int'(a) >= depth || a == 5'd31) return 64'h0;
    v = (m == 0) ? memA[a] : memB[a];
`ifdef REGFILE_BYPASS_EN
    if (we && wr == a) begin
      for (int k = 0; k < 4; k++) begin
        if (lane[k]) v[16*k +: 16] = wd[16*k +: 16];
      end
    end
`endif
    return v;
  endfunction

  // Model state update: clear on reset, otherwise apply the masked write.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        memA[i] = 64'h0;
        memB[i] = 64'h0;
      end
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane[k]) begin
          if (wr != 5'd31) memA[wr][16*k +: 16] = wd[16*k +: 16];
          if (int'(wr) < 24 && wr != 5'd31) memB[wr][16*k +: 16] = wd[16*k +: 16];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [63:0] d,
                               input logic [3:0] l, input logic [4:0] a1, input logic [4:0] a2);
    we = w;
    wr = wa;
    wd = d;
    lane = l;
    rr1 = a1;
    rr2 = a2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomPhase(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                    4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      nextCycle();
    end
  endtask

  // Compare every output of both instances with the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("cmp_rd1_d32", rd1a, modelRead(0, rr1));
    checkOutput("cmp_rd2_d32", rd2a, modelRead(0, rr2));
    checkOutput("cmp_rd1_d24", rd1b, modelRead(1, rr1));
    checkOutput("cmp_rd2_d24", rd2b, modelRead(1, rr2));
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      memA[i] = 64'h0;
      memB[i] = 64'h0;
    end
    $display("[TB] start");
    applyStimulus(1'b0, 5'd0, 64'h0, 4'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    randomPhase(300);

    // Reset with arbitrary contents: every index reads 0 on both ports.
    applyStimulus(1'b0, 5'd0, 64'h0, 4'h0, 5'd0, 5'd0);
    reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a);
      rr2 = 5'(31 - a);
      #1;
      checkOutput("reset_rd1", rd1a, 64'h0);
      checkOutput("reset_rd2", rd2a, 64'h0);
    end
    nextCycle();
    reset = 1'b0;

    // Full write of reg 5, then read it on both ports.
    applyStimulus(1'b1, 5'd5, 64'h0123456789ABCDEF, 4'hF, 5'd5, 5'd5);
    nextCycle();
    applyStimulus(1'b0, 5'd5, 64'h0, 4'h0, 5'd5, 5'd5);
    #2;
    checkOutput("full_wr_rd1", rd1a, 64'h0123456789ABCDEF);
    checkOutput("full_wr_rd2", rd2a, 64'h0123456789ABCDEF);
    nextCycle();

    // Lane-masked write to reg 5, then an idle cycle that must not change it.
    applyStimulus(1'b1, 5'd5, 64'hFFFFFFFFFFFFFFFF, 4'b0101, 5'd5, 5'd5);
    nextCycle();
    applyStimulus(1'b0, 5'd5, 64'h0, 4'hF, 5'd5, 5'd5);
    #2;
    checkOutput("lane_wr", rd1a, 64'h0123FFFF89ABFFFF);
    nextCycle();
    #2;
    checkOutput("nowrite_hold", rd2a, 64'h0123FFFF89ABFFFF);
    nextCycle();

    // A write to the zero register is ignored.
    applyStimulus(1'b1, 5'd31, 64'hDEADBEEFDEADBEEF, 4'hF, 5'd31, 5'd5);
    nextCycle();
    applyStimulus(1'b0, 5'd31, 64'h0, 4'h0, 5'd31, 5'd5);
    #2;
    checkOutput("zero_reg", rd1a, 64'h0);
    checkOutput("zero_reg_other", rd2a, 64'h0123FFFF89ABFFFF);
    nextCycle();

    // Read during write to the same address.
    applyStimulus(1'b1, 5'd7, 64'h1111, 4'hF, 5'd7, 5'd7);
    nextCycle();
    applyStimulus(1'b1, 5'd7, 64'h2222, 4'hF, 5'd7, 5'd7);
    #2;
`ifdef REGFILE_BYPASS_EN
    checkOutput("rdw_before", rd1a, 64'h2222);
`else
    checkOutput("rdw_before", rd1a, 64'h1111);
`endif
    nextCycle();
    applyStimulus(1'b0, 5'd7, 64'h0, 4'h0, 5'd7, 5'd7);
    #2;
    checkOutput("rdw_after", rd1a, 64'h2222);
    nextCycle();

    // Out-of-range write on the DEPTH=24 instance; index 28 is valid on DEPTH=32.
    applyStimulus(1'b1, 5'd28, 64'hCAFEF00DCAFEF00D, 4'hF, 5'd28, 5'd23);
    nextCycle();
    applyStimulus(1'b0, 5'd28, 64'h0, 4'h0, 5'd28, 5'd5);
    #2;
    checkOutput("oor_d24", rd1b, 64'h0);
    checkOutput("inrange_d32", rd1a, 64'hCAFEF00DCAFEF00D);
    checkOutput("d24_reg5", rd2b, 64'h0123FFFF89ABFFFF);
    for (int a = 0; a < 24; a++) begin
      rr1 = 5'(a);
      #1;
      checkOutput("d24_unchanged", rd1b, modelRead(1, rr1));
    end
    nextCycle();

    // Reset asserted mid-cycle during a write to reg 3.
    applyStimulus(1'b1, 5'd3, 64'hA5A5A5A5A5A5A5A5, 4'hF, 5'd3, 5'd3);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 64'h5A5A5A5A5A5A5A5A, 4'hF, 5'd3, 5'd3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_d32", rd1a, 64'h0);
    checkOutput("midrst_d24", rd2b, 64'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd3, 64'h0, 4'h0, 5'd3, 5'd3);
    reset = 1'b0;
    #1;
    checkOutput("postrst_d32", rd1a, 64'h0);
    checkOutput("postrst_d24", rd2b, 64'h0);
    nextCycle();

    randomPhase(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
